// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU datapath widths, register-zero index and the ALU
//               status flag layout used by the ALU wrapper and register file.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int FLAG_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;

    // Bit order is fixed: {carryout, zero, overflow, negative}, MSB first.
    typedef struct packed {
        logic carryout;
        logic zero;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/alu_status_reg.sv
`default_nettype none
// ============================================================================
// Module      : alu_status_reg
// Description : ALU status flag register with synchronous active-low clear
//               and load enable. Clear has priority over load.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_status_reg
    import cpu_pkg::*;
#(
    parameter int FLAG_W = cpu_pkg::FLAG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [FLAG_W-1:0] i_flags,
    output logic [FLAG_W-1:0] o_flags
);

    logic [FLAG_W-1:0] r_flags;

    // Capture flags on load, clear on reset, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flags <= '0;
        end else if (i_load) begin
            r_flags <= i_flags;
        end
    end

    assign o_flags = r_flags;

endmodule : alu_status_reg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32x32 MIPS general register file. Two combinational read
//               ports with same-cycle write bypass, one write port, register
//               zero hardwired to 0, plus the ALU status flag register.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int FLAG_W = cpu_pkg::FLAG_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic [FLAG_W-1:0] flag_in,
    output logic [FLAG_W-1:0] flags
);

    localparam int                C_NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] C_REG_ZERO = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [C_NUM_REGS];

    logic w_wr_live;
    logic w_byp_a;
    logic w_byp_b;

    // A write is only effective outside reset and to a non-zero register;
    // the same qualifier gates the bypass so reset shows pre-clear contents.
    assign w_wr_live = reset_n && wr_en && (wr_addr != C_REG_ZERO);
    assign w_byp_a   = w_wr_live && (wr_addr == rd_addr_a);
    assign w_byp_b   = w_wr_live && (wr_addr == rd_addr_b);

    // Register array: clear every entry on reset, else perform the live write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Read muxes: register zero forced low, then bypass, then array contents.
    always_comb begin
        bus_a = r_regs[rd_addr_a];
        bus_b = r_regs[rd_addr_b];
        if (w_byp_a) begin
            bus_a = wr_data;
        end
        if (w_byp_b) begin
            bus_b = wr_data;
        end
        if (rd_addr_a == C_REG_ZERO) begin
            bus_a = '0;
        end
        if (rd_addr_b == C_REG_ZERO) begin
            bus_b = '0;
        end
    end

    alu_status_reg #(
        .FLAG_W (FLAG_W)
    ) u_alu_status_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (flag_we),
        .i_flags (flag_in),
        .o_flags (flags)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Directed self-checking testbench for reg_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        reset_n;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic [3:0]  flags;

    int tests_run;
    int tests_failed;

    reg_file dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .bus_a     (bus_a),
        .bus_b     (bus_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        flag_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        flag_we = 1'b1; flag_in = 4'b1111;
        tick();
        idle();
        rd_addr_a = 5'd5; #1;
        tests_run++;
        if (bus_a !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL reset_prewrite r5: got %h exp %h", bus_a, 32'hDEADBEEF);
        end
        // During reset the bypass must be off: pre-clear contents visible.
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111; #1;
        tests_run++;
        if (bus_a !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL reset_bypass_gated: got %h exp %h", bus_a, 32'hDEADBEEF);
        end
        tick();
        reset_n = 1'b1; idle(); #1;
        tests_run++;
        if (bus_a !== 32'h0) begin
            tests_failed++; $display("FAIL reset_r5_clear: got %h exp %h", bus_a, 32'h0);
        end
        tests_run++;
        if (flags !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags: got %b exp %b", flags, 4'b0000);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678;
        tick();
        idle();
        rd_addr_a = 5'd3; rd_addr_b = 5'd4; #1;
        tests_run++;
        if (bus_a !== 32'h12345678) begin
            tests_failed++; $display("FAIL write_read r3: got %h exp %h", bus_a, 32'h12345678);
        end
        tests_run++;
        if (bus_b !== 32'h0) begin
            tests_failed++; $display("FAIL write_read r4: got %h exp %h", bus_b, 32'h0);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0; #1;
        tests_run++;
        if (bus_a !== 32'h0) begin
            tests_failed++; $display("FAIL zero_same_cycle a: got %h exp %h", bus_a, 32'h0);
        end
        tests_run++;
        if (bus_b !== 32'h0) begin
            tests_failed++; $display("FAIL zero_same_cycle b: got %h exp %h", bus_b, 32'h0);
        end
        tick();
        idle(); #1;
        tests_run++;
        if (bus_a !== 32'h0) begin
            tests_failed++; $display("FAIL zero_next_cycle: got %h exp %h", bus_a, 32'h0);
        end
    endtask

    task automatic test_bypass();
        rd_addr_a = 5'd7; rd_addr_b = 5'd7; #1;
        tests_run++;
        if (bus_a !== 32'h0) begin
            tests_failed++; $display("FAIL bypass_pre r7: got %h exp %h", bus_a, 32'h0);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D; #1;
        tests_run++;
        if (bus_a !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL bypass a: got %h exp %h", bus_a, 32'hCAFEF00D);
        end
        tests_run++;
        if (bus_b !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL bypass b: got %h exp %h", bus_b, 32'hCAFEF00D);
        end
        tick();
        idle(); #1;
        tests_run++;
        if (bus_a !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL bypass_hold r7: got %h exp %h", bus_a, 32'hCAFEF00D);
        end
    endtask

    task automatic test_flags();
        flag_we = 1'b1; flag_in = 4'b1010;
        tick();
        tests_run++;
        if (flags !== 4'b1010) begin
            tests_failed++; $display("FAIL flags_load: got %b exp %b", flags, 4'b1010);
        end
        flag_we = 1'b0; flag_in = 4'b0101;
        tick();
        tests_run++;
        if (flags !== 4'b1010) begin
            tests_failed++; $display("FAIL flags_hold: got %b exp %b", flags, 4'b1010);
        end
        flag_we = 1'b1; flag_in = 4'b0011; #1;
        tests_run++;
        if (flags !== 4'b1010) begin
            tests_failed++; $display("FAIL flags_no_bypass: got %b exp %b", flags, 4'b1010);
        end
        tick();
        flag_we = 1'b0;
        tests_run++;
        if (flags !== 4'b0011) begin
            tests_failed++; $display("FAIL flags_reload: got %b exp %b", flags, 4'b0011);
        end
    endtask

    task automatic test_back_to_back();
        // Write and flag capture in the same cycle.
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hA5A5A5A5;
        flag_we = 1'b1; flag_in = 4'b0110;
        tick();
        flag_we = 1'b0;
        wr_addr = 5'd2; wr_data = 32'h5A5A5A5A;
        rd_addr_a = 5'd1; rd_addr_b = 5'd2; #1;
        tests_run++;
        if (bus_a !== 32'hA5A5A5A5) begin
            tests_failed++; $display("FAIL b2b r1: got %h exp %h", bus_a, 32'hA5A5A5A5);
        end
        tests_run++;
        if (bus_b !== 32'h5A5A5A5A) begin
            tests_failed++; $display("FAIL b2b r2_bypass: got %h exp %h", bus_b, 32'h5A5A5A5A);
        end
        tests_run++;
        if (flags !== 4'b0110) begin
            tests_failed++; $display("FAIL b2b flags: got %b exp %b", flags, 4'b0110);
        end
        tick();
        idle();
        rd_addr_a = 5'd3; rd_addr_b = 5'd31; #1;
        tests_run++;
        if (bus_a !== 32'h12345678) begin
            tests_failed++; $display("FAIL b2b r3_unchanged: got %h exp %h", bus_a, 32'h12345678);
        end
        tests_run++;
        if (bus_b !== 32'h0) begin
            tests_failed++; $display("FAIL b2b r31_unchanged: got %h exp %h", bus_b, 32'h0);
        end
    endtask

    task automatic test_reset_vs_write();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
        tick();
        reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
        flag_we = 1'b1; flag_in = 4'b1111;
        tick();
        reset_n = 1'b1; idle();
        rd_addr_a = 5'd9; rd_addr_b = 5'd7; #1;
        tests_run++;
        if (bus_a !== 32'h0) begin
            tests_failed++; $display("FAIL rst_vs_wr r9: got %h exp %h", bus_a, 32'h0);
        end
        tests_run++;
        if (bus_b !== 32'h0) begin
            tests_failed++; $display("FAIL rst_vs_wr r7: got %h exp %h", bus_b, 32'h0);
        end
        tests_run++;
        if (flags !== 4'b0000) begin
            tests_failed++; $display("FAIL rst_vs_wr flags: got %b exp %b", flags, 4'b0000);
        end
        // Fresh start after reset.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D;
        tick();
        idle(); #1;
        tests_run++;
        if (bus_a !== 32'h0BADF00D) begin
            tests_failed++; $display("FAIL post_reset_write r9: got %h exp %h", bus_a, 32'h0BADF00D);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        flag_we = 1'b0; flag_in = '0;
        tick();
        tick();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_flags();
        test_back_to_back();
        test_reset_vs_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
